// File: rtl/sub_sched_pkg.sv
// sub_sched_pkg: shared types, constants and the round-robin pick helper
// for the shared subtract scheduler (sub_sched).
//   state_t  - operation sequencer states (IDLE, LO, HI, RESP)
//   pick_t   - result of a round-robin search (found flag + index)
//   rr_pick  - first valid requester at or after a pointer, with wrap
package sub_sched_pkg;

  localparam int WORD_W  = 32;
  localparam int DWORD_W = 64;
  // Widest requester count the pick helper supports; callers zero-pad.
  localparam int MAX_REQ = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    RESP = 2'd3
  } state_t;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } pick_t;

  // Search upward from ptr, wrapping modulo n. The loop runs downward so
  // that the smallest offset from ptr is the last (winning) assignment.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                    input logic [2:0]         ptr,
                                    input logic [3:0]         n);
    pick_t      p;
    logic [3:0] j;
    p = '0;
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      j = {1'b0, ptr} + 4'(k);
      if (j >= n) j = j - n;
      if ((4'(k) < n) && valid[j[2:0]]) begin
        p.found = 1'b1;
        p.idx   = j[2:0];
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/sub_sched_sub_word.sv
// sub_word: purely combinational 32-bit ripple-borrow subtractor.
//   a, b  - minuend / subtrahend word
//   bin   - borrow-in
//   diff  - a - b - bin modulo 2^32
//   bout  - borrow-out (1 when a - b - bin < 0 as unsigned)
module sub_word
  import sub_sched_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              bin,
  output logic [WORD_W-1:0] diff,
  output logic              bout
);

  logic [WORD_W:0] borrow;

  assign borrow[0] = bin;

  generate
    for (genvar gi = 0; gi < WORD_W; gi++) begin : g_bit
      assign diff[gi]       = a[gi] ^ b[gi] ^ borrow[gi];
      // Borrow out of a bit when b exceeds a, or they are equal and a
      // borrow is already arriving from below.
      assign borrow[gi + 1] = (~a[gi] & b[gi]) | (~(a[gi] ^ b[gi]) & borrow[gi]);
    end
  endgenerate

  assign bout = borrow[WORD_W];

endmodule

// File: rtl/sub_sched.sv
// sub_sched: round-robin scheduler sharing one 32-bit subtract unit among
// NUM_REQ requesters. Single-word ops take one pass (LO); double-word ops
// take two passes (LO then HI) with the borrow registered between them.
// Optional feature macro: SUB_SCHED_OVF_EN adds rsp_ovf (signed overflow
// of the final word, registered with the result).
// Ports:
//   clk, reset          - clock, asynchronous active-high reset
//   req_valid/req_ready - per-requester handshake (ready is one-hot or 0)
//   req_dw, req_bin     - per-requester double-word flag and borrow-in
//   req_a, req_b        - flattened 64-bit operands, requester i at [64i+:64]
//   rsp_valid/rsp_ready - result handshake
//   rsp_id, rsp_diff, rsp_bout - owner index, difference, final borrow
module sub_sched
  import sub_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ-1:0]         req_dw,
  input  logic [NUM_REQ*DWORD_W-1:0] req_a,
  input  logic [NUM_REQ*DWORD_W-1:0] req_b,
  input  logic [NUM_REQ-1:0]         req_bin,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [ID_W-1:0]            rsp_id,
  output logic [DWORD_W-1:0]         rsp_diff,
  output logic                       rsp_bout
`ifdef SUB_SCHED_OVF_EN
  ,
  output logic                       rsp_ovf
`endif
);

  state_t state_reg, state_next;

  logic [ID_W-1:0]    rr_ptr_reg;
  logic [DWORD_W-1:0] a_reg, b_reg;
  logic               bin_reg, dw_reg;
  logic [ID_W-1:0]    id_reg;
  logic               borrow_reg;
  logic [WORD_W-1:0]  diff_lo_reg, diff_hi_reg;
  logic               bout_reg;

  // Per-requester operand views of the flattened buses.
  logic [DWORD_W-1:0] a_arr [NUM_REQ];
  logic [DWORD_W-1:0] b_arr [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign a_arr[gi] = req_a[gi*DWORD_W +: DWORD_W];
      assign b_arr[gi] = req_b[gi*DWORD_W +: DWORD_W];
    end
  endgenerate

  // Round-robin arbitration.
  logic [MAX_REQ-1:0] valid_pad;
  pick_t              pick;
  logic [ID_W-1:0]    grant_id;
  logic               accept;

  assign valid_pad = MAX_REQ'(req_valid);
  assign pick      = rr_pick(valid_pad, 3'(rr_ptr_reg), 4'(NUM_REQ));
  assign grant_id  = ID_W'(pick.idx);

  // Word mux into the shared unit: high halves and the carried borrow in
  // HI, low halves and the requester's borrow-in otherwise.
  logic [WORD_W-1:0] w_a, w_b, w_diff;
  logic              w_bin, w_bout;

  always_comb begin
    if (state_reg == HI) begin
      w_a   = a_reg[DWORD_W-1:WORD_W];
      w_b   = b_reg[DWORD_W-1:WORD_W];
      w_bin = borrow_reg;
    end else begin
      w_a   = a_reg[WORD_W-1:0];
      w_b   = b_reg[WORD_W-1:0];
      w_bin = bin_reg;
    end
  end

  sub_word u_sub_word (
    .a    (w_a),
    .b    (w_b),
    .bin  (w_bin),
    .diff (w_diff),
    .bout (w_bout)
  );

`ifdef SUB_SCHED_OVF_EN
  // The mux already presents the word holding the final msb, so the same
  // expression serves single-word (LO) and double-word (HI) ops.
  logic ovf_word;
  logic ovf_reg;
  assign ovf_word = (w_a[WORD_W-1] != w_b[WORD_W-1]) &&
                    (w_diff[WORD_W-1] != w_a[WORD_W-1]);
`endif

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // FSM next-state and handshake outputs.
  always_comb begin
    state_next = state_reg;
    req_ready  = '0;
    rsp_valid  = 1'b0;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (pick.found) begin
          req_ready  = NUM_REQ'(1) << grant_id;
          accept     = 1'b1;
          state_next = LO;
        end
      end
      LO:   state_next = dw_reg ? HI : RESP;
      HI:   state_next = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, pass results and round-robin pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_reg  <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      bin_reg     <= 1'b0;
      dw_reg      <= 1'b0;
      id_reg      <= '0;
      borrow_reg  <= 1'b0;
      diff_lo_reg <= '0;
      diff_hi_reg <= '0;
      bout_reg    <= 1'b0;
`ifdef SUB_SCHED_OVF_EN
      ovf_reg     <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            a_reg      <= a_arr[grant_id];
            b_reg      <= b_arr[grant_id];
            bin_reg    <= req_bin[grant_id];
            dw_reg     <= req_dw[grant_id];
            id_reg     <= grant_id;
            rr_ptr_reg <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
          end
        end
        LO: begin
          diff_lo_reg <= w_diff;
          borrow_reg  <= w_bout;
          if (!dw_reg) begin
            diff_hi_reg <= '0;
            bout_reg    <= w_bout;
`ifdef SUB_SCHED_OVF_EN
            ovf_reg     <= ovf_word;
`endif
          end
        end
        HI: begin
          diff_hi_reg <= w_diff;
          bout_reg    <= w_bout;
`ifdef SUB_SCHED_OVF_EN
          ovf_reg     <= ovf_word;
`endif
        end
        default: ;
      endcase
    end
  end

  assign rsp_id   = id_reg;
  assign rsp_diff = {diff_hi_reg, diff_lo_reg};
  assign rsp_bout = bout_reg;
`ifdef SUB_SCHED_OVF_EN
  assign rsp_ovf  = ovf_reg;
`endif

endmodule

// File: tb/tb_sub_sched.sv
// tb_sub_sched: directed self-checking bench for sub_sched.
// Latency is counted in cycles from the cycle in which req_ready is seen
// high (cycle 0) to the cycle in which rsp_valid is seen high.
module tb_sub_sched;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ-1:0]     req_ready;
  logic [NUM_REQ-1:0]     req_dw;
  logic [NUM_REQ*64-1:0]  req_a;
  logic [NUM_REQ*64-1:0]  req_b;
  logic [NUM_REQ-1:0]     req_bin;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [ID_W-1:0]        rsp_id;
  logic [63:0]            rsp_diff;
  logic                   rsp_bout;
`ifdef SUB_SCHED_OVF_EN
  logic                   rsp_ovf;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  sub_sched #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_dw    (req_dw),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_bin   (req_bin),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_diff  (rsp_diff),
    .rsp_bout  (rsp_bout)
`ifdef SUB_SCHED_OVF_EN
    ,
    .rsp_ovf   (rsp_ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input logic [63:0] a, input logic [63:0] b,
                         input logic bin, input logic dw);
    req_a[64*id +: 64] = a;
    req_b[64*id +: 64] = b;
    req_bin[id]        = bin;
    req_dw[id]         = dw;
  endtask

  task automatic wait_rsp(input string tag, output int cycles);
    cycles = 0;
    while (rsp_valid !== 1'b1 && cycles < 10) begin
      step();
      cycles++;
    end
    check({tag, "_rsp_timeout"}, 64'(cycles < 10), 64'd1);
  endtask

  // Issue one op alone, wait for grant, follow it to the response.
  task automatic run_op(input string tag, input int id, input logic [63:0] a,
                        input logic [63:0] b, input logic bin, input logic dw,
                        input logic [63:0] exp_diff, input logic exp_bout,
                        input logic exp_ovf, input int exp_lat);
    int n;
    int lat;
    set_req(id, a, b, bin, dw);
    req_valid[id] = 1'b1;
    #1;
    n = 0;
    while (req_ready[id] !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check({tag, "_grant_timeout"}, 64'(n < 20), 64'd1);
    check({tag, "_ready"}, 64'(req_ready), 64'(1) << id);
    step();
    req_valid[id] = 1'b0;
    wait_rsp(tag, lat);
    lat = lat + 1;
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_id"}, 64'(rsp_id), 64'(id));
    check({tag, "_diff"}, rsp_diff, exp_diff);
    check({tag, "_bout"}, 64'(rsp_bout), 64'(exp_bout));
`ifdef SUB_SCHED_OVF_EN
    check({tag, "_ovf"}, 64'(rsp_ovf), 64'(exp_ovf));
`else
    if (exp_ovf) begin end
`endif
    $display("txn %s: id=%0d diff=0x%016h bout=%0d lat=%0d", tag, rsp_id, rsp_diff, rsp_bout, lat);
    step();
  endtask

  initial begin
    int n;
    int lat;
    int seen;
    reset     = 1'b1;
    req_valid = '0;
    req_dw    = '0;
    req_a     = '0;
    req_b     = '0;
    req_bin   = '0;
    rsp_ready = 1'b1;
    step();
    step();

    // Reset state.
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_valid", 64'(rsp_valid), 64'd0);
    check("rst_id",    64'(rsp_id),    64'd0);
    check("rst_diff",  rsp_diff,       64'd0);
    check("rst_bout",  64'(rsp_bout),  64'd0);
    reset = 1'b0;
    step();

    // Single-word ops, then a double-word borrow across the word boundary.
    run_op("sw_5m3", 0, 64'h5, 64'h3, 1'b0, 1'b0, 64'h2, 1'b0, 1'b0, 2);
    run_op("sw_0m1", 1, 64'h0, 64'h1, 1'b0, 1'b0, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b0, 2);
    run_op("dw_brw", 2, 64'h1_0000_0000, 64'h1, 1'b0, 1'b1,
           64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0, 3);

    // Backpressure: req 0 result held while req 3 waits.
    rsp_ready = 1'b0;
    set_req(0, 64'd10, 64'd4, 1'b0, 1'b0);
    req_valid[0] = 1'b1;
    #1;
    check("bp_ready0", 64'(req_ready), 64'b0001);
    step();
    req_valid[0] = 1'b0;
    set_req(3, 64'h2_0000_0005, 64'h1_0000_0007, 1'b0, 1'b1);
    req_valid[3] = 1'b1;
    wait_rsp("bp0", lat);
    for (int c = 0; c < 5; c++) begin
      check("bp_hold_valid", 64'(rsp_valid), 64'd1);
      check("bp_hold_diff",  rsp_diff,       64'd6);
      check("bp_hold_id",    64'(rsp_id),    64'd0);
      check("bp_hold_ready", 64'(req_ready), 64'd0);
      step();
    end
    $display("txn bp0: id=%0d diff=0x%016h held 5 cycles", rsp_id, rsp_diff);
    rsp_ready = 1'b1;
    step();
    check("bp_ready3", 64'(req_ready), 64'b1000);
    step();
    req_valid[3] = 1'b0;
    wait_rsp("bp3", lat);
    check("bp3_id",   64'(rsp_id),   64'd3);
    check("bp3_diff", rsp_diff,      64'h0000_0000_FFFF_FFFE);
    check("bp3_bout", 64'(rsp_bout), 64'd0);
    $display("txn bp3: id=%0d diff=0x%016h bout=%0d", rsp_id, rsp_diff, rsp_bout);
    step();

    // Round-robin fairness with all four held valid (pointer now at 0).
    for (int i = 0; i < NUM_REQ; i++)
      set_req(i, 64'(100 + 16 * i), 64'(i), 1'b0, 1'b0);
    req_valid = '1;
    #1;
    for (int g = 0; g < 5; g++) begin
      int exp_id;
      exp_id = g % NUM_REQ;
      n = 0;
      while (req_ready === '0 && n < 20) begin
        step();
        n++;
      end
      check("rr_grant_timeout", 64'(n < 20), 64'd1);
      check("rr_ready", 64'(req_ready), 64'(1) << exp_id);
      step();
      wait_rsp("rr", lat);
      check("rr_id",   64'(rsp_id), 64'(exp_id));
      check("rr_diff", rsp_diff,    64'(100 + 15 * exp_id));
      $display("txn rr: grant=%0d id=%0d diff=0x%016h", g, rsp_id, rsp_diff);
      step();
    end
    req_valid = '0;
    step();

    // Signed overflow of the final word (single- and double-word).
    run_op("ovf_sw", 2, 64'h8000_0000, 64'h1, 1'b0, 1'b0, 64'h7FFF_FFFF, 1'b0, 1'b1, 2);
    run_op("ovf_dw", 2, 64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1,
           64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 3);

    // Async reset during HI of a double-word op.
    set_req(1, 64'h5_0000_0000, 64'h1_0000_0001, 1'b0, 1'b1);
    req_valid[1] = 1'b1;
    #1;
    check("ar_ready", 64'(req_ready), 64'b0010);
    step();
    req_valid[1] = 1'b0;
    step();
    #2;
    reset = 1'b1;
    #1;
    check("ar_valid", 64'(rsp_valid), 64'd0);
    check("ar_ready0", 64'(req_ready), 64'd0);
    check("ar_id",    64'(rsp_id),    64'd0);
    check("ar_diff",  rsp_diff,       64'd0);
    check("ar_bout",  64'(rsp_bout),  64'd0);
`ifdef SUB_SCHED_OVF_EN
    check("ar_ovf",   64'(rsp_ovf),   64'd0);
`endif
    step();
    reset = 1'b0;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      if (rsp_valid === 1'b1) seen++;
      step();
    end
    check("ar_no_rsp", 64'(seen), 64'd0);
    $display("txn reset_abort: responses after reset=%0d", seen);
    // Pointer back at 0: with 1 and 2 valid, 1 wins.
    req_valid = 4'b0110;
    #1;
    check("ar_ptr", 64'(req_ready), 64'b0010);
    req_valid = '0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
